// File: rtl/vga_pkg.sv
// Shared constants and types for the 800x600@72 Hz test-pattern pipeline:
// timing numbers, colour width, pattern modes, bar colours and the per-axis bounce step.
package vga_pkg;

  localparam int H_DISPLAY = 800;
  localparam int H_FRONT   = 56;
  localparam int H_SYNC    = 120;
  localparam int H_BACK    = 64;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_DISPLAY = 600;
  localparam int V_FRONT   = 37;
  localparam int V_SYNC    = 6;
  localparam int V_BACK    = 23;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int COLOR_BITS = 4;

  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_CHECKER  = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_BOX      = 2'd3
  } mode_e;

  // Bar colours as {R,G,B} on/off flags, left to right.
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  typedef struct packed {
    logic [15:0] pos;
    logic        dir_pos;
  } axis_t;

  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

  // One frame of motion on one axis; reverses before the far edge would pass the limit.
  function automatic axis_t bounce_step(input logic [15:0] pos, input logic dir_pos,
                                        input logic [15:0] limit, input logic [15:0] size,
                                        input logic [15:0] step);
    axis_t       r;
    logic [16:0] far_edge;
    far_edge  = {1'b0, pos} + {1'b0, size} + {1'b0, step};
    r.dir_pos = dir_pos;
    if (dir_pos) begin
      if (far_edge > {1'b0, limit}) begin
        r.dir_pos = 1'b0;
        r.pos     = pos - step;
      end else begin
        r.pos = pos + step;
      end
    end else begin
      if (pos < step) begin
        r.dir_pos = 1'b1;
        r.pos     = pos + step;
      end else begin
        r.pos = pos - step;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_box_animator.sv
// Bouncing-box position: X/Y coordinates and directions, advanced once per frame tick.
module vga_box_animator
  import vga_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = H_DISPLAY,
  parameter int DISPLAY_HEIGHT = V_DISPLAY,
  parameter int BOX_SIZE       = 64,
  parameter int BOX_STEP       = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  output logic [15:0] box_x_o,
  output logic [15:0] box_y_o
);

  axis_t x_q, x_d, y_q, y_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q <= '{pos: 16'd0, dir_pos: 1'b1};
      y_q <= '{pos: 16'd0, dir_pos: 1'b1};
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick_i) begin
      x_d = bounce_step(x_q.pos, x_q.dir_pos, 16'(DISPLAY_WIDTH), 16'(BOX_SIZE), 16'(BOX_STEP));
      y_d = bounce_step(y_q.pos, y_q.dir_pos, 16'(DISPLAY_HEIGHT), 16'(BOX_SIZE), 16'(BOX_STEP));
    end
  end

  assign box_x_o = x_q.pos;
  assign box_y_o = y_q.pos;

endmodule

// File: rtl/vga_test_pattern_gen.sv
// Two-stage pixel colour pipeline (pattern, then blanking) with syncs delayed to match.
// Optional build macro VGA_TEST_PATTERN_BORDER_EN forces a white one-pixel frame border.
module vga_test_pattern_gen
  import vga_pkg::*;
#(
  parameter int DISPLAY_WIDTH    = H_DISPLAY,
  parameter int DISPLAY_HEIGHT   = V_DISPLAY,
  parameter int COLOR_W          = COLOR_BITS,
  parameter int CELL_LOG2        = 5,
  parameter int BOX_SIZE         = 64,
  parameter int BOX_STEP         = 4,
  parameter bit SYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic               clkIn,
  input  logic               rstIn,
  input  logic [15:0]        hPosIn,
  input  logic [15:0]        vPosIn,
  input  logic               isDisplayOnIn,
  input  logic               isHSyncIn,
  input  logic               isVSyncIn,
  input  logic [1:0]         modeIn,
  output logic [COLOR_W-1:0] rOut,
  output logic [COLOR_W-1:0] gOut,
  output logic [COLOR_W-1:0] bOut,
  output logic               hSyncOut,
  output logic               vSyncOut,
  output logic               frameTickOut
);

  localparam int BAR_W = DISPLAY_WIDTH / 8;

  logic [COLOR_W-1:0] r1_q, g1_q, b1_q, r1_d, g1_d, b1_d;
  logic [COLOR_W-1:0] r2_q, g2_q, b2_q, r2_d, g2_d, b2_d;
  logic               de1_q, hs1_q, vs1_q, hs2_q, vs2_q;
  logic               vs_prev_q, tick_q, tick_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  mode_e              mode_q, mode_d;
  logic [15:0]        box_x, box_y;
  logic [2:0]         bar_idx, bar_rgb;
  logic               checker_on, in_box;

  vga_box_animator #(
    .DISPLAY_WIDTH (DISPLAY_WIDTH),
    .DISPLAY_HEIGHT(DISPLAY_HEIGHT),
    .BOX_SIZE      (BOX_SIZE),
    .BOX_STEP      (BOX_STEP)
  ) u_box (
    .clk_i  (clkIn),
    .rst_i  (rstIn),
    .tick_i (tick_q),
    .box_x_o(box_x),
    .box_y_o(box_y)
  );

  // Frame-rate state only moves on the tick, so the pattern never changes mid-frame.
  always_comb begin
    tick_d      = isVSyncIn & ~vs_prev_q;
    frame_cnt_d = tick_q ? frame_cnt_q + 8'd1 : frame_cnt_q;
    mode_d      = tick_q ? mode_e'(modeIn) : mode_q;
  end

  // Comparator chain: the smallest matching boundary is written last and wins.
  always_comb begin
    bar_idx = 3'd7;
    for (int i = 7; i >= 1; i--) begin
      if (hPosIn < 16'(i * BAR_W)) bar_idx = 3'(i - 1);
    end
  end

  assign bar_rgb    = bar_color(bar_idx);
  assign checker_on = hPosIn[CELL_LOG2] ^ vPosIn[CELL_LOG2] ^ frame_cnt_q[6];
  assign in_box     = (hPosIn >= box_x) && ({1'b0, hPosIn} < ({1'b0, box_x} + 17'(BOX_SIZE))) &&
                      (vPosIn >= box_y) && ({1'b0, vPosIn} < ({1'b0, box_y} + 17'(BOX_SIZE)));

  always_comb begin
    r1_d = '0;
    g1_d = '0;
    b1_d = '0;
    case (mode_q)
      MODE_BARS: begin
        r1_d = {COLOR_W{bar_rgb[2]}};
        g1_d = {COLOR_W{bar_rgb[1]}};
        b1_d = {COLOR_W{bar_rgb[0]}};
      end
      MODE_CHECKER: begin
        r1_d = {COLOR_W{checker_on}};
        g1_d = {COLOR_W{checker_on}};
        b1_d = {COLOR_W{checker_on}};
      end
      MODE_GRADIENT: begin
        r1_d = hPosIn[9 -: COLOR_W];
        g1_d = vPosIn[9 -: COLOR_W];
        b1_d = frame_cnt_q[7 -: COLOR_W];
      end
      MODE_BOX: begin
        r1_d = {COLOR_W{in_box}};
        g1_d = {COLOR_W{in_box}};
        b1_d = in_box ? {COLOR_W{1'b1}} : COLOR_W'(1);
      end
      default: ;
    endcase
`ifdef VGA_TEST_PATTERN_BORDER_EN
    if (hPosIn == 16'd0 || hPosIn == 16'(DISPLAY_WIDTH - 1) ||
        vPosIn == 16'd0 || vPosIn == 16'(DISPLAY_HEIGHT - 1)) begin
      r1_d = '1;
      g1_d = '1;
      b1_d = '1;
    end
`endif
  end

  always_comb begin
    r2_d = de1_q ? r1_q : '0;
    g2_d = de1_q ? g1_q : '0;
    b2_d = de1_q ? b1_q : '0;
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r1_q        <= '0;
      g1_q        <= '0;
      b1_q        <= '0;
      de1_q       <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      r2_q        <= '0;
      g2_q        <= '0;
      b2_q        <= '0;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
      vs_prev_q   <= 1'b0;
      tick_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
      mode_q      <= MODE_BARS;
    end else begin
      r1_q        <= r1_d;
      g1_q        <= g1_d;
      b1_q        <= b1_d;
      de1_q       <= isDisplayOnIn;
      hs1_q       <= isHSyncIn;
      vs1_q       <= isVSyncIn;
      r2_q        <= r2_d;
      g2_q        <= g2_d;
      b2_q        <= b2_d;
      hs2_q       <= hs1_q;
      vs2_q       <= vs1_q;
      vs_prev_q   <= isVSyncIn;
      tick_q      <= tick_d;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
    end
  end

  assign rOut         = r2_q;
  assign gOut         = g2_q;
  assign bOut         = b2_q;
  assign hSyncOut     = SYNC_ACTIVE_HIGH ? hs2_q : ~hs2_q;
  assign vSyncOut     = SYNC_ACTIVE_HIGH ? vs2_q : ~vs2_q;
  assign frameTickOut = tick_q;

endmodule
